// File: rtl/conway_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conway_pkg
// Purpose  : Shared types and constants for the Conway generation scheduler:
//            scheduler state encoding, default widths, watchdog default and
//            the ping-pong direction encoding.
// Revision : 1.0  initial release
// ============================================================================
package conway_pkg;

    // Default configuration values
    localparam int FDIV_W_DEF         = 8;
    localparam int GCNT_W_DEF         = 32;
    localparam int TIMEOUT_CYCLES_DEF = 200000;

    // Ping-pong direction encoding.
    // DIR_M1_CUR: accelerator reads m1 / writes m2, VGA displays m1.
    // DIR_M2_CUR: the roles of the two memories are swapped.
    localparam logic DIR_M1_CUR = 1'b0;
    localparam logic DIR_M2_CUR = 1'b1;

    // Scheduler states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        GEN       = 3'd2,
        WAIT_SWAP = 3'd3,
        SWAP      = 3'd4
    } sched_state_e;

    // The buffer that was being computed becomes the displayed one.
    function automatic logic dir_flip(input logic dir);
        return (dir == DIR_M1_CUR) ? DIR_M2_CUR : DIR_M1_CUR;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conway_gen_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : conway_gen_sched_if
// Purpose  : Start/done handshake between the generation scheduler and the
//            Conway accelerator.
//   gen_start : one-cycle pulse, scheduler -> accelerator, begin generation
//   gen_done  : one-cycle pulse, accelerator -> scheduler, generation written
// Modports : master (scheduler side), slave (accelerator side)
// Revision : 1.0  initial release
// ============================================================================
interface conway_gen_sched_if;

    logic gen_start;
    logic gen_done;

    modport master (
        output gen_start,
        input  gen_done
    );

    modport slave (
        input  gen_start,
        output gen_done
    );

endinterface
`default_nettype wire

// File: rtl/conway_eof_pacer.sv
`default_nettype none
// ============================================================================
// Module   : conway_eof_pacer
// Purpose  : Divides the VGA end-of-frame pulse stream. Every end-of-frame
//            advances a counter; the pulse on which the counter equals the
//            divider is a launch slot and the counter restarts at 0.
//            The divider is compared live, so a new value takes effect on
//            the next end-of-frame.
// Ports    : clk, reset       clock, synchronous active-high reset
//            i_vga_eof        end-of-frame pulse
//            i_frame_div      divider (slot every i_frame_div+1 pulses)
//            o_slot           combinational, high in the cycle of a slot eof
// Revision : 1.0  initial release
// ============================================================================
module conway_eof_pacer #(
    parameter int FDIV_W = 8
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              i_vga_eof,
    input  wire logic [FDIV_W-1:0] i_frame_div,
    output logic                   o_slot
);

    logic [FDIV_W-1:0] cnt_q;
    logic [FDIV_W-1:0] cnt_d;
    logic              w_hit;

    always_comb begin
        w_hit  = (cnt_q == i_frame_div);
        cnt_d  = cnt_q;
        o_slot = 1'b0;
        if (i_vga_eof) begin
            if (w_hit) begin
                cnt_d  = '0;
                o_slot = 1'b1;
            end else begin
                cnt_d  = cnt_q + FDIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/conway_gen_sched.sv
`default_nettype none
// ============================================================================
// Module   : conway_gen_sched
// Purpose  : Frame sequencer for the Conway accelerator. On a paced VGA
//            end-of-frame it launches one generation, waits for the
//            accelerator to finish, and swaps the display/compute buffers
//            only at an end-of-frame so the display never tears.
// Ports    : clk, reset   clock, synchronous active-high reset
//            vga_eof      end-of-frame pulse from the VGA controller
//            run          level, free-running generations
//            step         pulse, one generation while run=0
//            frame_div    launch every frame_div+1 end-of-frame pulses
//            acc          start/done handshake (master modport)
//            direction    ping-pong buffer select (see conway_pkg)
//            busy         high from gen_start until the swap completes
//            gen_count    completed swaps, wraps
//            overrun      sticky, a launch slot passed while not idle
//            err_clr      pulse, clears sticky error flags
//            timeout      sticky watchdog flag     (CONWAY_GEN_TIMEOUT_EN)
//            gen_abort    one-cycle abort pulse    (CONWAY_GEN_TIMEOUT_EN)
// Options  : CONWAY_GEN_TIMEOUT_EN adds a watchdog on the GEN state with
//            parameter TIMEOUT_CYCLES and the timeout/gen_abort ports.
// Revision : 1.0  initial release
// ============================================================================
module conway_gen_sched
    import conway_pkg::*;
#(
    parameter int FDIV_W = FDIV_W_DEF,
    parameter int GCNT_W = GCNT_W_DEF
`ifdef CONWAY_GEN_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              vga_eof,
    input  wire logic              run,
    input  wire logic              step,
    input  wire logic [FDIV_W-1:0] frame_div,
    conway_gen_sched_if.master     acc,
    output logic                   direction,
    output logic                   busy,
    output logic [GCNT_W-1:0]      gen_count,
    output logic                   overrun,
    input  wire logic              err_clr
`ifdef CONWAY_GEN_TIMEOUT_EN
    ,
    output logic                   timeout,
    output logic                   gen_abort
`endif
);

    sched_state_e      state_q;
    sched_state_e      state_d;
    logic              direction_q;
    logic              direction_d;
    logic [GCNT_W-1:0] gen_count_q;
    logic [GCNT_W-1:0] gen_count_d;
    logic              overrun_q;
    logic              overrun_d;
    logic              step_pending_q;
    logic              step_pending_d;
    logic              w_slot;
    logic              w_swap_next;

    conway_eof_pacer #(
        .FDIV_W      (FDIV_W)
    ) u_pacer (
        .clk         (clk),
        .reset       (reset),
        .i_vga_eof   (vga_eof),
        .i_frame_div (frame_div),
        .o_slot      (w_slot)
    );

`ifdef CONWAY_GEN_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q;
    logic [WD_W-1:0] wd_d;
    logic            timeout_q;
    logic            timeout_d;
    logic            w_abort;

    // Counter holds the number of GEN cycles already elapsed; the abort
    // fires in the TIMEOUT_CYCLES-th GEN cycle unless gen_done arrives then.
    always_comb begin
        wd_d    = '0;
        w_abort = 1'b0;
        if (state_q == GEN) begin
            wd_d = wd_q + WD_W'(1);
            if (!acc.gen_done && (wd_q == WD_W'(TIMEOUT_CYCLES - 1))) begin
                w_abort = 1'b1;
            end
        end
        timeout_d = timeout_q;
        if (err_clr) begin
            timeout_d = 1'b0;
        end
        if (w_abort) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout   = timeout_q;
    assign gen_abort = w_abort;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (w_slot && (run || step_pending_q)) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = GEN;
            end
            GEN: begin
                // A done that coincides with end-of-frame needs no extra wait.
                if (acc.gen_done) begin
                    state_d = vga_eof ? SWAP : WAIT_SWAP;
                end
`ifdef CONWAY_GEN_TIMEOUT_EN
                else if (w_abort) begin
                    state_d = IDLE;
                end
`endif
            end
            WAIT_SWAP: begin
                if (vga_eof) begin
                    state_d = SWAP;
                end
            end
            SWAP: begin
                // Launch is only considered at a later slot.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath registers. direction and gen_count update on the edge that
    // enters SWAP, so the swap is visible one cycle after the qualifying eof.
    always_comb begin
        w_swap_next = (state_d == SWAP);

        direction_d = direction_q;
        gen_count_d = gen_count_q;
        if (w_swap_next) begin
            direction_d = dir_flip(direction_q);
            gen_count_d = gen_count_q + GCNT_W'(1);
        end

        // A new overrun event has priority over a simultaneous clear.
        overrun_d = overrun_q;
        if (err_clr) begin
            overrun_d = 1'b0;
        end
        if (w_slot && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        // A step arriving in the launch cycle is a fresh request and is kept.
        step_pending_d = step_pending_q;
        if (state_q == LAUNCH) begin
            step_pending_d = 1'b0;
        end
        if (step && !run) begin
            step_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            direction_q    <= DIR_M1_CUR;
            gen_count_q    <= '0;
            overrun_q      <= 1'b0;
            step_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            direction_q    <= direction_d;
            gen_count_q    <= gen_count_d;
            overrun_q      <= overrun_d;
            step_pending_q <= step_pending_d;
        end
    end

    assign acc.gen_start = (state_q == LAUNCH);
    assign busy          = (state_q != IDLE);
    assign direction     = direction_q;
    assign gen_count     = gen_count_q;
    assign overrun       = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_conway_gen_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_conway_gen_sched
// Purpose  : Self-checking bench for conway_gen_sched. Directed scenarios
//            plus randomized end-of-frame spacing, run/step patterns and
//            accelerator latency against a frame-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_conway_gen_sched;

    localparam int FDIV_W = 8;
    localparam int GCNT_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              vga_eof;
    logic              run;
    logic              step;
    logic              err_clr;
    logic [FDIV_W-1:0] frame_div;
    logic              direction;
    logic              busy;
    logic              overrun;
    logic [GCNT_W-1:0] gen_count;
`ifdef CONWAY_GEN_TIMEOUT_EN
    logic              timeout;
    logic              gen_abort;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    conway_gen_sched_if acc ();

    conway_gen_sched #(
        .FDIV_W         (FDIV_W),
        .GCNT_W         (GCNT_W)
`ifdef CONWAY_GEN_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (100)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .vga_eof   (vga_eof),
        .run       (run),
        .step      (step),
        .frame_div (frame_div),
        .acc       (acc),
        .direction (direction),
        .busy      (busy),
        .gen_count (gen_count),
        .overrun   (overrun),
        .err_clr   (err_clr)
`ifdef CONWAY_GEN_TIMEOUT_EN
        ,
        .timeout   (timeout),
        .gen_abort (gen_abort)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- drive helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        vga_eof      = 1'b0;
        run          = 1'b0;
        step         = 1'b0;
        err_clr      = 1'b0;
        frame_div    = '0;
        acc.gen_done = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One end-of-frame pulse; returns gen_start as seen the following cycle.
    task automatic pulse_eof(output bit st);
        vga_eof = 1'b1;
        tick();
        vga_eof = 1'b0;
        st = acc.gen_start;
    endtask

    // Idle cycles after an eof. The accelerator answers gen_done lat cycles
    // after the launch (lat=0 withholds it); step pulses at cycle step_at.
    task automatic gap_run(input int gap, input bit launched, input int lat,
                           input int step_at, output int starts);
        starts = 0;
        for (int i = 1; i < gap; i++) begin
            acc.gen_done = launched && (lat != 0) && (i == lat);
            step         = (step_at != 0) && (i == step_at);
            tick();
            if (acc.gen_start) starts++;
        end
        acc.gen_done = 1'b0;
        step         = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_cmp++; if (acc.gen_start !== 1'b0) begin n_bad++; $display("FAIL reset_gen_start got %0b want 0", acc.gen_start); end
        n_cmp++; if (direction !== 1'b0) begin n_bad++; $display("FAIL reset_direction got %0b want 0", direction); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_cmp++; if (gen_count !== '0) begin n_bad++; $display("FAIL reset_gen_count got %0d want 0", gen_count); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun got %0b want 0", overrun); end
    endtask

    task automatic test_run_pacing();
        bit st;
        bit exp_dir;
        int s;
        int tot;
        do_reset();
        run = 1'b1;
        frame_div = 8'd0;
        exp_dir = 1'b0;
        tot = 0;
        for (int e = 1; e <= 6; e++) begin
            pulse_eof(st);
            if (e % 2 == 0) exp_dir = ~exp_dir;
            n_cmp++; if (st !== bit'(e % 2)) begin n_bad++; $display("FAIL pacing_start eof%0d got %0b want %0b", e, st, e % 2); end
            n_cmp++; if (direction !== exp_dir) begin n_bad++; $display("FAIL pacing_dir eof%0d got %0b want %0b", e, direction, exp_dir); end
            gap_run(1000, st, 50, 0, s);
            tot += s;
        end
        n_cmp++; if (tot !== 0) begin n_bad++; $display("FAIL pacing_stray_starts got %0d want 0", tot); end
        n_cmp++; if (gen_count !== 32'd3) begin n_bad++; $display("FAIL pacing_count got %0d want 3", gen_count); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL pacing_busy got %0b want 0", busy); end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL pacing_overrun got %0b want 1", overrun); end
    endtask

    task automatic test_frame_div();
        bit st;
        int s;
        int tot;
        do_reset();
        run = 1'b1;
        frame_div = 8'd2;
        tot = 0;
        for (int e = 1; e <= 9; e++) begin
            pulse_eof(st);
            n_cmp++; if (st !== bit'(e % 3 == 0)) begin n_bad++; $display("FAIL fdiv_start eof%0d got %0b want %0b", e, st, e % 3 == 0); end
            gap_run(1000, st, 50, 0, s);
            tot += s;
        end
        n_cmp++; if (tot !== 0) begin n_bad++; $display("FAIL fdiv_stray_starts got %0d want 0", tot); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL fdiv_overrun got %0b want 0", overrun); end
        n_cmp++; if (gen_count !== 32'd2) begin n_bad++; $display("FAIL fdiv_count got %0d want 2", gen_count); end
        n_cmp++; if (direction !== 1'b0) begin n_bad++; $display("FAIL fdiv_dir got %0b want 0", direction); end
    endtask

    task automatic test_step();
        bit st;
        int s;
        int tot;
        do_reset();
        run = 1'b0;
        frame_div = 8'd0;
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        pulse_eof(st);
        n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL step_start got %0b want 1", st); end
        gap_run(1000, st, 50, 0, s);
        tot = s;
        for (int e = 2; e <= 11; e++) begin
            pulse_eof(st);
            if (st) tot++;
            if (e == 2) begin
                n_cmp++; if (direction !== 1'b1) begin n_bad++; $display("FAIL step_swap_dir got %0b want 1", direction); end
            end
            gap_run(1000, st, 50, 0, s);
            tot += s;
        end
        n_cmp++; if (tot !== 0) begin n_bad++; $display("FAIL step_extra_starts got %0d want 0", tot); end
        n_cmp++; if (gen_count !== 32'd1) begin n_bad++; $display("FAIL step_count got %0d want 1", gen_count); end
    endtask

    task automatic test_coincident();
        bit st;
        do_reset();
        run = 1'b1;
        frame_div = 8'd0;
        pulse_eof(st);
        repeat (20) tick();
        vga_eof = 1'b1;
        acc.gen_done = 1'b1;
        tick();
        vga_eof = 1'b0;
        acc.gen_done = 1'b0;
        n_cmp++; if (direction !== 1'b1) begin n_bad++; $display("FAIL coinc_dir got %0b want 1", direction); end
        n_cmp++; if (gen_count !== 32'd1) begin n_bad++; $display("FAIL coinc_count got %0d want 1", gen_count); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL coinc_busy_swap got %0b want 1", busy); end
        n_cmp++; if (acc.gen_start !== 1'b0) begin n_bad++; $display("FAIL coinc_no_launch got %0b want 0", acc.gen_start); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL coinc_busy_after got %0b want 0", busy); end
    endtask

    task automatic test_overrun();
        bit st;
        int s;
        do_reset();
        run = 1'b1;
        frame_div = 8'd0;
        pulse_eof(st);
        gap_run(300, st, 0, 0, s);
        pulse_eof(st);
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set got %0b want 1", overrun); end
        n_cmp++; if (st !== 1'b0) begin n_bad++; $display("FAIL ovr_no_launch got %0b want 0", st); end
        repeat (3) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clear got %0b want 0", overrun); end
        gap_run(300, 1'b0, 0, 0, s);
        vga_eof = 1'b1;
        err_clr = 1'b1;
        tick();
        vga_eof = 1'b0;
        err_clr = 1'b0;
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set_wins got %0b want 1", overrun); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clear2 got %0b want 0", overrun); end
        acc.gen_done = 1'b1;
        tick();
        acc.gen_done = 1'b0;
        tick();
        pulse_eof(st);
        n_cmp++; if (direction !== 1'b1) begin n_bad++; $display("FAIL ovr_late_swap_dir got %0b want 1", direction); end
        n_cmp++; if (gen_count !== 32'd1) begin n_bad++; $display("FAIL ovr_late_swap_count got %0d want 1", gen_count); end
    endtask

    task automatic test_reset_mid_gen();
        bit st;
        do_reset();
        run = 1'b1;
        frame_div = 8'd0;
        pulse_eof(st);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (direction !== 1'b0) begin n_bad++; $display("FAIL rstgen_dir got %0b want 0", direction); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstgen_busy got %0b want 0", busy); end
        n_cmp++; if (gen_count !== '0) begin n_bad++; $display("FAIL rstgen_count got %0d want 0", gen_count); end
        // gen_done while idle must be ignored
        acc.gen_done = 1'b1;
        tick();
        acc.gen_done = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstgen_done_ignored got %0b want 0", busy); end
        // finished generation waiting for eof, then reset: eof launches anew
        pulse_eof(st);
        repeat (3) tick();
        acc.gen_done = 1'b1;
        tick();
        acc.gen_done = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pulse_eof(st);
        n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL rstwait_launch got %0b want 1", st); end
        n_cmp++; if (direction !== 1'b0) begin n_bad++; $display("FAIL rstwait_dir got %0b want 0", direction); end
    endtask

    // Frame-level model: each eof is either a slot or not (divider count),
    // a finished generation is shown at the first eof after it, and an idle
    // scheduler launches at a slot when run or a step request is present.
    task automatic test_random();
        bit st;
        int s;
        int tot;
        int fd, lat, gap, step_at;
        int m_cnt;
        bit m_slot, m_inflight, m_pend, m_dir, m_ovr, exp_launch;
        int m_count;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            fd  = $urandom_range(0, 3);
            lat = $urandom_range(2, 60);
            frame_div = FDIV_W'(fd);
            run = 1'b1;
            m_cnt = 0; m_inflight = 0; m_pend = 0; m_dir = 0; m_ovr = 0; m_count = 0;
            tot = 0;
            for (int e = 0; e < 16; e++) begin
                m_slot = (m_cnt == fd);
                m_cnt  = m_slot ? 0 : m_cnt + 1;
                exp_launch = 1'b0;
                if (m_inflight) begin
                    m_dir = ~m_dir;
                    m_count++;
                    m_inflight = 1'b0;
                    if (m_slot) m_ovr = 1'b1;
                end else if (m_slot && (run || m_pend)) begin
                    exp_launch = 1'b1;
                    m_pend = 1'b0;
                    m_inflight = 1'b1;
                end
                pulse_eof(st);
                n_cmp++; if (st !== exp_launch) begin n_bad++; $display("FAIL rand_start r%0d eof%0d got %0b want %0b", r, e, st, exp_launch); end
                n_cmp++; if (direction !== m_dir) begin n_bad++; $display("FAIL rand_dir r%0d eof%0d got %0b want %0b", r, e, direction, m_dir); end
                run = ($urandom_range(0, 3) != 0);
                step_at = 0;
                if (!run && ($urandom_range(0, 1) == 1)) begin
                    step_at = $urandom_range(lat + 2, lat + 4);
                    m_pend = 1'b1;
                end
                gap = $urandom_range(lat + 6, lat + 150);
                gap_run(gap, st, lat, step_at, s);
                tot += s;
            end
            n_cmp++; if (tot !== 0) begin n_bad++; $display("FAIL rand_stray_starts r%0d got %0d want 0", r, tot); end
            n_cmp++; if (gen_count !== GCNT_W'(m_count)) begin n_bad++; $display("FAIL rand_count r%0d got %0d want %0d", r, gen_count, m_count); end
            n_cmp++; if (overrun !== m_ovr) begin n_bad++; $display("FAIL rand_overrun r%0d got %0b want %0b", r, overrun, m_ovr); end
            n_cmp++; if (busy !== m_inflight) begin n_bad++; $display("FAIL rand_busy r%0d got %0b want %0b", r, busy, m_inflight); end
        end
    endtask

`ifdef CONWAY_GEN_TIMEOUT_EN
    task automatic test_timeout();
        bit st;
        int early;
        do_reset();
        run = 1'b1;
        frame_div = 8'd0;
        pulse_eof(st);
        early = 0;
        for (int i = 1; i < 100; i++) begin
            tick();
            if (gen_abort) early++;
        end
        n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL to_early_abort got %0d want 0", early); end
        tick();
        n_cmp++; if (gen_abort !== 1'b1) begin n_bad++; $display("FAIL to_abort got %0b want 1", gen_abort); end
        tick();
        n_cmp++; if (gen_abort !== 1'b0) begin n_bad++; $display("FAIL to_abort_pulse got %0b want 0", gen_abort); end
        n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL to_flag got %0b want 1", timeout); end
        n_cmp++; if (direction !== 1'b0) begin n_bad++; $display("FAIL to_dir got %0b want 0", direction); end
        n_cmp++; if (gen_count !== '0) begin n_bad++; $display("FAIL to_count got %0d want 0", gen_count); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL to_busy got %0b want 0", busy); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL to_clear got %0b want 0", timeout); end
    endtask
`endif

    initial begin
        test_reset();
        test_run_pacing();
        test_frame_div();
        test_step();
        test_coincident();
        test_overrun();
        test_reset_mid_gen();
        test_random();
`ifdef CONWAY_GEN_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL sim_time_limit reached got running want finished");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire

// File: doc/conway_gen_sched.md
Name: conway_gen_sched

Overview:
Sequences the Conway accelerator across frames, and owns the ping-pong direction bit for the two cell memories. On a paced VGA end-of-frame it launches one generation and waits for the accelerator to finish. It then swaps display/compute buffers only at the next end-of-frame, so the display never tears. It sits between the VGA controller, the HPS control registers and the accelerator's start/done interface.

Parameters:
FDIV_W, 8, width of frame_div (generation rate divider)
GCNT_W, 32, width of generation counter
TIMEOUT_CYCLES, 200000, watchdog limit in clk cycles (used only with GEN_TIMEOUT_EN)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
vga_eof  input  1  one-cycle pulse at end of visible frame (start of vblank)
run  input  1  level; free-running generation when high
step  input  1  one-cycle pulse; request exactly one generation while run=0
frame_div  input  FDIV_W  launch a generation every frame_div+1 end-of-frame pulses
gen_start  output  1  one-cycle pulse to accelerator: begin generation
gen_done  input  1  one-cycle pulse from accelerator: generation written
direction  output  1  0: accel reads m1/writes m2, VGA reads m1; 1: swapped
busy  output  1  high from gen_start until swap completes
gen_count  output  GCNT_W  number of completed swaps
overrun  output  1  sticky: a paced launch slot passed while not IDLE
err_clr  input  1  pulse; clears sticky error flags

Behaviour:
- Reset values: state IDLE, gen_start=0, direction=0, busy=0, gen_count=0, overrun=0, pacing counter=0, step_pending=0.
- Pacing counter: increments on each vga_eof. When the counter equals frame_div, that vga_eof is a "slot" and the counter returns to 0. frame_div=0 makes every vga_eof a slot. frame_div is sampled live.
- step_pending: set by step while run=0; cleared when gen_start fires. step is ignored while run=1.
- IDLE: on a slot with (run | step_pending), go to LAUNCH. Otherwise stay.
- LAUNCH (1 cycle): gen_start=1, busy=1, go to GEN.
- GEN:
  - gen_done moves to WAIT_SWAP.
  - gen_done and vga_eof in the same cycle move directly to SWAP.
  - A slot arriving while in GEN sets overrun.
- WAIT_SWAP: on the next vga_eof (slot or not), go to SWAP. A slot arriving here also sets overrun.
- SWAP (1 cycle):
  - direction toggles; gen_count increments, wrapping modulo 2^GCNT_W.
  - busy drops the cycle after SWAP.
  - Return to IDLE. The launch decision is re-evaluated at the next slot, never in the SWAP cycle.
- Latency: slot to gen_start is 1 cycle. A swap is visible on direction 1 cycle after the qualifying vga_eof.
- run falling during GEN/WAIT_SWAP: the current generation completes and swaps; then IDLE with no further launches.
- gen_done outside GEN is ignored.
- err_clr and a new overrun event in the same cycle: set wins.
- Synchronous reset mid-generation: immediate return to reset values, no swap. The accelerator must be reset by the same signal.

Optional Feature:
Macro CONWAY_GEN_TIMEOUT_EN.
- With the macro defined:
  - A watchdog counts cycles in GEN.
  - Reaching TIMEOUT_CYCLES sets sticky output timeout (1 bit, cleared by err_clr) and pulses output gen_abort for one cycle.
  - The state returns to IDLE without toggling direction or incrementing gen_count.
- Without the macro: no timeout/gen_abort ports and no watchdog logic; GEN waits indefinitely.

Decomposition:
- conway_pkg holds:
  - state enum (IDLE, LAUNCH, GEN, WAIT_SWAP, SWAP);
  - localparams for default widths and TIMEOUT_CYCLES;
  - the direction encoding constants DIR_M1_CUR / DIR_M2_CUR.
- One sub-module is natural: conway_eof_pacer (pacing counter plus slot pulse output), instantiated once.

Test Plan:
- Reset, run=1, frame_div=0, accelerator model answers gen_done 50 cycles after gen_start, eof every 1000 cycles:
  - gen_start 1 cycle after each eof;
  - direction toggles 1 cycle after the following eof;
  - gen_count=3 after 6 eofs.
- frame_div=2, run=1: gen_start only on eofs 3, 6, 9 (1-based); no overrun.
- run=0, single step pulse:
  - exactly one gen_start at the next eof, then one swap;
  - no further launches over 10 eofs; gen_count=1.
- gen_done coincident with eof: SWAP the next cycle (direction toggles 1 cycle after that eof), no extra eof wait.
- Accelerator model withholds gen_done for 2 eofs with frame_div=0: overrun=1 after the first missed slot; err_clr returns it to 0.
- Reset asserted while in GEN: the next cycle shows direction=0, busy=0, gen_count=0, and no swap occurs. With CONWAY_GEN_TIMEOUT_EN and TIMEOUT_CYCLES=100, a withheld gen_done gives gen_abort at cycle 100 of GEN, timeout=1, and direction unchanged.
